// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared definitions for the I2C config-table sequencer: reserved dev codes,
// FSM encoding and entry-field helpers.
package i2c_cfg_sequencer_pkg;

  localparam logic [7:0] DEV_SKIP_C  = 8'h00;
  localparam logic [7:0] DEV_DELAY_C = 8'hfe;
  localparam logic [7:0] DEV_END_C   = 8'hff;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_WAIT,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  // Entry layout is {dev[7:0], reg, data} with data in the LSBs.
  function automatic int entry_reg_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int entry_dev_lsb(input int reg_w, input int data_w);
    return reg_w + data_w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Delay-entry timer: prescaler producing one tick per PRESC cycles feeding a down-counter.
// expired asserts in the cycle the last tick lands, so the caller sees exactly count*PRESC cycles.
module cfg_delay_timer
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int          CNT_W = 8,
  parameter int unsigned PRESC = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             expired
);

  localparam int PW = width_of(PRESC);

  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  assign tick    = count && (presc_q == PW'(PRESC - 1));
  assign expired = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      presc_q <= '0;
      cnt_q   <= load_val;
    end else if (count) begin
      if (tick) begin
        presc_q <= '0;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a {dev,reg,data} config table and issues one I2C write per entry, with
// skip/delay/end entries, NACK retry and done/error status.
module i2c_cfg_sequencer
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int          INDEX_W    = 10,
  parameter int          REG_W      = 16,
  parameter int          DATA_W     = 8,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TICK_US    = 1000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter bit          AUTO_START = 1'b1,
  parameter logic [7:0]  DEV_SKIP   = DEV_SKIP_C,
  parameter logic [7:0]  DEV_DELAY  = DEV_DELAY_C,
  parameter logic [7:0]  DEV_END    = DEV_END_C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [INDEX_W-1:0]        lut_index,
  input  logic [8+REG_W+DATA_W-1:0] lut_data,
  output logic                      i2c_req,
  output logic [7:0]                i2c_dev_addr,
  output logic [REG_W-1:0]          i2c_reg_addr,
  output logic [DATA_W-1:0]         i2c_wdata,
  input  logic                      i2c_ack,
  input  logic                      i2c_nack,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [INDEX_W-1:0]        err_index
);

  localparam int          ENTRY_W = 8 + REG_W + DATA_W;
  localparam int          REG_LSB = entry_reg_lsb(DATA_W);
  localparam int          DEV_LSB = entry_dev_lsb(REG_W, DATA_W);
  localparam int unsigned PRESC   = CLK_HZ / 1000000 * TICK_US;
  localparam int          RETRY_W = width_of(MAX_RETRY + 1);

  state_t               state, next_state;
  logic [ENTRY_W-1:0]   entry_q;
  logic [RETRY_W-1:0]   retry_q;
  logic                 auto_pend_q;
  logic                 timer_expired;

  logic [7:0]           ent_dev;
  logic [REG_W-1:0]     ent_reg;
  logic [DATA_W-1:0]    ent_data;
  logic                 last_index;
  logic                 retry_ok;

  logic start_run, entry_cap, issue, ack_ok, nack_retry, advance;
  logic timer_load, timer_count, busy_nxt, req_nxt;

  assign ent_dev    = entry_q[DEV_LSB +: 8];
  assign ent_reg    = entry_q[REG_LSB +: REG_W];
  assign ent_data   = entry_q[0 +: DATA_W];
  assign last_index = (lut_index == '1);
  assign retry_ok   = (retry_q < RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (start || auto_pend_q) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (ent_dev == DEV_END)        next_state = S_DONE;
        else if (ent_dev == DEV_SKIP)  next_state = S_NEXT;
        else if (ent_dev == DEV_DELAY) next_state = (ent_data == '0) ? S_NEXT : S_DELAY;
        else                           next_state = S_REQ;
      end
      S_REQ:    next_state = S_WAIT;
      // A simultaneous ack and nack is treated as a nack.
      S_WAIT: begin
        if (i2c_nack)     next_state = retry_ok ? S_REQ : S_ERR;
        else if (i2c_ack) next_state = S_NEXT;
      end
      S_DELAY:  if (timer_expired) next_state = S_NEXT;
      S_NEXT:   next_state = last_index ? S_DONE : S_FETCH;
      S_DONE:   next_state = S_IDLE;
      S_ERR:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    start_run   = (state == S_IDLE) && (start || auto_pend_q);
    entry_cap   = (state == S_FETCH);
    issue       = (state == S_REQ);
    ack_ok      = (state == S_WAIT) && i2c_ack && !i2c_nack;
    nack_retry  = (state == S_WAIT) && i2c_nack && retry_ok;
    advance     = (state == S_NEXT) && !last_index;
    timer_load  = (state == S_DECODE);
    timer_count = (state == S_DELAY);
    busy_nxt    = !(next_state inside {S_IDLE, S_DONE, S_ERR});
    req_nxt     = (next_state == S_WAIT);
  end

  // busy and i2c_req are registered from next_state so they are glitch-free flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_index    <= '0;
      entry_q      <= '0;
      retry_q      <= '0;
      auto_pend_q  <= AUTO_START;
      i2c_req      <= 1'b0;
      i2c_dev_addr <= '0;
      i2c_reg_addr <= '0;
      i2c_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_index    <= '0;
    end else begin
      auto_pend_q <= 1'b0;
      busy        <= busy_nxt;
      i2c_req     <= req_nxt;
      if (start_run) begin
        lut_index <= '0;
        retry_q   <= '0;
        done      <= 1'b0;
        error     <= 1'b0;
      end
      if (entry_cap) entry_q <= lut_data;
      if (issue) begin
        i2c_dev_addr <= ent_dev;
        i2c_reg_addr <= ent_reg;
        i2c_wdata    <= ent_data;
      end
      if (ack_ok)     retry_q <= '0;
      if (nack_retry) retry_q <= retry_q + 1'b1;
      if (advance)    lut_index <= lut_index + 1'b1;
      if (next_state == S_DONE) done <= 1'b1;
      if (next_state == S_ERR) begin
        error     <= 1'b1;
        err_index <= lut_index;
      end
    end
  end

  cfg_delay_timer #(
    .CNT_W (DATA_W),
    .PRESC (PRESC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (ent_data),
    .count    (timer_count),
    .expired  (timer_expired)
  );

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: bench LUT + I2C master model (responds after 20 cycles),
// request/status scoreboards checked by a negedge monitor.
module tb_i2c_cfg_sequencer;

  localparam int IW = 3;
  localparam int RW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          i2c_ack = 1'b0;
  logic          i2c_nack = 1'b0;
  logic [IW-1:0] lut_index, err_index;
  logic [31:0]   lut_data;
  logic          i2c_req, busy, done, error;
  logic [7:0]    i2c_dev_addr;
  logic [RW-1:0] i2c_reg_addr;
  logic [DW-1:0] i2c_wdata;

  always #5 clk = ~clk;

  i2c_cfg_sequencer #(
    .INDEX_W(IW), .REG_W(RW), .DATA_W(DW), .CLK_HZ(1000000), .TICK_US(10),
    .MAX_RETRY(3), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
    .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_wdata(i2c_wdata), .i2c_ack(i2c_ack), .i2c_nack(i2c_nack), .busy(busy),
    .done(done), .error(error), .err_index(err_index)
  );

  logic [31:0] lut [0:7];
  assign lut_data = lut[lut_index];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [2:0] idx; logic [31:0] ent; } req_t;
  typedef struct packed { logic d; logic e; logic [2:0] ei; logic [2:0] li; } st_t;
  req_t exp_q[$];
  int   gap_q[$];
  st_t  st_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // I2C master model: responds 20 cycles after i2c_req is seen high.
  int mcnt = 0;
  int nack_left [0:7];
  always @(negedge clk) begin
    i2c_ack  = 1'b0;
    i2c_nack = 1'b0;
    if (rst || !i2c_req) mcnt = 0;
    else begin
      mcnt++;
      if (mcnt == 20) begin
        mcnt = 0;
        if (nack_left[lut_index] > 0) begin
          nack_left[lut_index]--;
          i2c_nack = 1'b1;
        end else i2c_ack = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboards on each request rise and each done/error rise.
  logic req_prev = 1'b0;
  logic st_prev = 1'b0;
  int   last_rise = 0;
  req_t exp_r;
  int   exp_g;
  st_t  exp_s;
  always @(negedge clk) begin
    if (i2c_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_req: got index %0d dev %h expected none", lut_index, i2c_dev_addr);
      end else begin
        exp_r = exp_q.pop_front();
        exp_g = gap_q.pop_front();
        check("req_fields", {29'd0, lut_index, i2c_dev_addr, i2c_reg_addr, i2c_wdata}, {29'd0, exp_r});
        if (exp_g != 0) check("req_gap", 64'(cyc - last_rise), 64'(exp_g));
      end
      last_rise = cyc;
    end
    req_prev = i2c_req;
    if ((done || error) && !st_prev) begin
      if (st_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_status: got done %b error %b expected none", done, error);
      end else begin
        exp_s = st_q.pop_front();
        check("status", {56'd0, done, error, err_index, lut_index}, {56'd0, exp_s});
      end
    end
    st_prev = done || error;
  end

  task automatic push(input int idx, input int gap);
    exp_q.push_back({3'(idx), lut[idx]});
    gap_q.push_back(gap);
  endtask

  task automatic push_st(input logic d, input logic e, input int ei, input int li);
    st_q.push_back({d, e, 3'(ei), 3'(li)});
  endtask

  task automatic clear_lut();
    for (int i = 0; i < 8; i++) begin
      lut[i] = 32'hff000000;
      nack_left[i] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!((done || error) && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got busy %b after %0d cycles expected idle", name, busy, n);
    end
    repeat (3) @(negedge clk);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset_check(input string name);
    @(negedge clk) rst = 1'b1;
    #1;
    check({name, "_req_async"}, 64'(i2c_req), 64'd0);
    check({name, "_busy_async"}, 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    clear_lut();
    // Test 1: auto-start write-only table
    lut[0] = 32'h78_3103_11;
    lut[1] = 32'h78_3008_82;
    lut[2] = 32'h78_3017_02;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(i2c_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_lut_index", 64'(lut_index), 64'd0);
    check("rst_err_index", 64'(err_index), 64'd0);
    push(0, 0); push(1, 24); push(2, 24); push_st(1, 0, 0, 3);
    rst = 1'b0;
    wait_end("t1");

    // Test 2: skip entry mid-table
    clear_lut();
    lut[0] = 32'h78_0001_aa;
    lut[1] = 32'h00_1234_56;
    lut[2] = 32'h78_0002_bb;
    push(0, 0); push(2, 27); push_st(1, 0, 0, 3);
    pulse_start();
    wait_end("t2");

    // Test 3: delay of 5 ticks, zero delay, start while busy ignored
    clear_lut();
    lut[0] = 32'h78_0010_01;
    lut[1] = 32'hfe_0000_05;
    lut[2] = 32'h78_0011_02;
    lut[3] = 32'hfe_0000_00;
    lut[4] = 32'h78_0012_03;
    push(0, 0); push(2, 77); push(4, 27); push_st(1, 0, 0, 5);
    pulse_start();
    repeat (40) @(negedge clk);
    pulse_start();
    wait_end("t3");

    // Test 4a: two NACKs then ACK on index 2
    clear_lut();
    for (int i = 0; i < 3; i++) lut[i] = {8'h78, 16'(16'h0100 + i), 8'(i)};
    nack_left[2] = 2;
    push(0, 0); push(1, 24); push(2, 24); push(2, 21); push(2, 21); push_st(1, 0, 0, 3);
    pulse_start();
    wait_end("t4a");

    // Test 4b: retries exhausted on index 2
    nack_left[2] = 4;
    push(0, 0); push(1, 24); push(2, 24); push(2, 21); push(2, 21); push(2, 21);
    push_st(0, 1, 2, 2);
    pulse_start();
    wait_end("t4b");
    repeat (100) @(negedge clk);
    check("t4b_busy_idle", 64'(busy), 64'd0);
    check("t4b_error_held", 64'(error), 64'd1);

    // Test 5: full table with no terminator, no wrap
    clear_lut();
    for (int i = 0; i < 8; i++) lut[i] = {8'h78, 16'(16'h0200 + i), 8'(8'h10 + i)};
    push(0, 0);
    for (int i = 1; i < 8; i++) push(i, 24);
    push_st(1, 0, 2, 7);
    pulse_start();
    wait_end("t5");
    repeat (10) @(negedge clk);
    check("t5_no_wrap", 64'(lut_index), 64'd7);

    // Test 6a: reset during WAIT, auto restart from index 0
    clear_lut();
    lut[0] = 32'h78_4000_01;
    lut[1] = 32'h78_4001_02;
    lut[2] = 32'h78_4002_03;
    push(0, 0);
    pulse_start();
    n = 0;
    while (!i2c_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6a_req_seen", 64'(i2c_req), 64'd1);
    repeat (5) @(negedge clk);
    push(0, 0); push(1, 24); push(2, 24); push_st(1, 0, 0, 3);
    do_reset_check("t6a");
    wait_end("t6a");

    // Test 6b: reset during DELAY
    clear_lut();
    lut[0] = 32'hfe_0000_05;
    lut[1] = 32'h78_00aa_55;
    pulse_start();
    repeat (20) @(negedge clk);
    check("t6b_busy_in_delay", 64'(busy), 64'd1);
    check("t6b_no_req_in_delay", 64'(i2c_req), 64'd0);
    push(1, 0); push_st(1, 0, 0, 2);
    do_reset_check("t6b");
    wait_end("t6b");

    check("final_status_queue", 64'(st_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
